accel_conditioner: RTL

Upstream stage of the velocity integrator. It takes raw signed accelerometer samples and removes a calibrated zero-g offset. It then averages samples in fixed-size windows, applies a deadband, and measures the sample-window period in clock cycles. It presents a stable acceleration value `a`, a matching time step `dt` and a one-cycle `enable` to the integrator, gated by the integrator's `busy`.

---
 rtl/accel_conditioner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/accel_conditioner.sv
// Accelerometer front end: zero-g offset calibration, windowed averaging with deadband,
// window period measurement, and a busy-gated single-cycle hand-off to the integrator.
module accel_conditioner #(
  parameter int unsigned CAL_SHIFT = 4,
  parameter int unsigned AVG_SHIFT = 2,
  parameter logic [15:0] DEADBAND  = 16'd8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic        [15:0] raw,
  input  logic               raw_valid,
  input  logic               recal,
  input  logic               busy,
  output logic signed [15:0] a,
  output logic        [15:0] dt,
  output logic               enable,
  output logic               calibrated,
  output logic signed [15:0] offset,
  output logic               overrun
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = DW + CAL_SHIFT;
  localparam int unsigned AW = DW + AVG_SHIFT;
  localparam logic [CAL_SHIFT-1:0] CAL_LAST = '1;
  localparam logic [AVG_SHIFT-1:0] AVG_LAST = '1;
  localparam logic signed [16:0] DB_POS = 17'({1'b0, DEADBAND});
  localparam logic signed [16:0] DB_NEG = -DB_POS;

  typedef enum logic {CAL, RUN} state_t;

  state_t state, next_state;

  logic signed [CW-1:0]    cal_acc, cal_sum;
  logic [CAL_SHIFT-1:0]    cal_cnt;
  logic signed [AW-1:0]    win_acc, win_sum;
  logic [AVG_SHIFT-1:0]    win_cnt;
  logic [15:0]             period;
  logic                    pending;
  logic signed [15:0]      pend_a;
  logic [15:0]             pend_dt;

  logic signed [16:0]      diff_wide;
  logic signed [15:0]      diff_sat;
  logic signed [15:0]      avg_raw;
  logic signed [16:0]      avg_ext;
  logic signed [15:0]      avg_db;
  logic                    cal_done, win_done, issue;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= CAL;
    else      state <= next_state;
  end

  // Next state and per-cycle event decode
  always_comb begin
    next_state = state;
    cal_done   = 1'b0;
    win_done   = 1'b0;
    issue      = 1'b0;
    if (!recal) begin
      if (raw_valid && state == CAL && cal_cnt == CAL_LAST) cal_done = 1'b1;
      if (raw_valid && state == RUN && win_cnt == AVG_LAST) win_done = 1'b1;
      if (state == RUN && pending && !busy && !enable)       issue    = 1'b1;
    end
    if (recal)         next_state = CAL;
    else if (cal_done) next_state = RUN;
  end

  // Offset removal with saturation, window average and deadband
  always_comb begin
    cal_sum   = cal_acc + {{CAL_SHIFT{raw[15]}}, raw};
    diff_wide = {raw[15], raw} - {offset[15], offset};
    if (diff_wide[16] != diff_wide[15])
      diff_sat = diff_wide[16] ? 16'sh8000 : 16'sh7FFF;
    else
      diff_sat = diff_wide[15:0];
    win_sum = win_acc + {{AVG_SHIFT{diff_sat[15]}}, diff_sat};
    avg_raw = win_sum[AW-1:AVG_SHIFT];
    avg_ext = {avg_raw[15], avg_raw};
    avg_db  = avg_raw;
    if (avg_ext > DB_NEG && avg_ext < DB_POS) avg_db = 16'sd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a          <= '0;
      dt         <= '0;
      enable     <= 1'b0;
      calibrated <= 1'b0;
      offset     <= '0;
      overrun    <= 1'b0;
      cal_acc    <= '0;
      cal_cnt    <= '0;
      win_acc    <= '0;
      win_cnt    <= '0;
      period     <= '0;
      pending    <= 1'b0;
      pend_a     <= '0;
      pend_dt    <= '0;
    end else if (recal) begin
      // offset, a and dt keep their last values across recalibration
      enable     <= 1'b0;
      calibrated <= 1'b0;
      overrun    <= 1'b0;
      cal_acc    <= '0;
      cal_cnt    <= '0;
      win_acc    <= '0;
      win_cnt    <= '0;
      period     <= '0;
      pending    <= 1'b0;
    end else begin
      enable <= issue;
      if (issue) begin
        a       <= pend_a;
        dt      <= pend_dt;
        pending <= 1'b0;
      end
      if (state == CAL) begin
        if (raw_valid) begin
          cal_acc <= cal_sum;
          cal_cnt <= cal_cnt + CAL_SHIFT'(1);
        end
        if (cal_done) begin
          offset     <= cal_sum[CW-1:CAL_SHIFT];
          calibrated <= 1'b1;
          cal_acc    <= '0;
          win_acc    <= '0;
          win_cnt    <= '0;
          period     <= 16'd1;
        end
      end else begin
        if (win_done)               period <= 16'd1;
        else if (period != 16'hFFFF) period <= period + 16'd1;
        if (raw_valid) begin
          win_acc <= win_sum;
          win_cnt <= win_cnt + AVG_SHIFT'(1);
        end
        // A new result overwrites an unissued one unless it leaves this same edge
        if (win_done) begin
          pend_a  <= avg_db;
          pend_dt <= period;
          pending <= 1'b1;
          win_acc <= '0;
          if (pending && !issue) overrun <= 1'b1;
        end
      end
    end
  end

endmodule
